// File: rtl/pn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pn_pkg
// Purpose  : Shared encodings, state/error enums and helpers for the PN feeder.
// Revision : 1.0  initial release
// ============================================================================
package pn_pkg;

    localparam int PN_MAX_TOK = 12;

    localparam logic [1:0] PN_MODE_GRP_PRE  = 2'd0;
    localparam logic [1:0] PN_MODE_GRP_POST = 2'd1;
    localparam logic [1:0] PN_MODE_NPN      = 2'd2;
    localparam logic [1:0] PN_MODE_RPN      = 2'd3;

    localparam logic [2:0] PN_OP_ADD    = 3'd0;
    localparam logic [2:0] PN_OP_SUB    = 3'd1;
    localparam logic [2:0] PN_OP_MUL    = 3'd2;
    localparam logic [2:0] PN_OP_ABSADD = 3'd3;

    typedef enum logic [1:0] {
        PN_ERR_NONE   = 2'd0,
        PN_ERR_COUNT  = 2'd1,
        PN_ERR_STRUCT = 2'd2,
        PN_ERR_OVF    = 2'd3
    } pn_err_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4
    } pn_state_e;

    // Grouped modes take whole triples; the stack modes take odd lengths 5..9.
    function automatic logic pn_count_ok(input logic [1:0] mode, input int n);
        if (mode == PN_MODE_GRP_PRE || mode == PN_MODE_GRP_POST)
            return (n == 6) || (n == 9) || (n == 12);
        return (n == 5) || (n == 7) || (n == 9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pn_token_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pn_token_feeder_if
// Purpose  : Host write port and evaluator-side signals of the token feeder.
// Revision : 1.0  initial release
// ============================================================================
interface pn_token_feeder_if #(
    parameter int TOKW = 3
);
    logic            wr_valid;
    logic            wr_ready;
    logic [1:0]      wr_mode;
    logic            wr_operator;
    logic [TOKW-1:0] wr_data;
    logic            wr_last;
    logic [1:0]      mode;
    logic            operator;
    logic [TOKW-1:0] in;
    logic            in_valid;
    logic            pn_out_valid;
    logic            busy;
    logic            err;
    logic [1:0]      err_code;

    modport master (
        output wr_valid, wr_mode, wr_operator, wr_data, wr_last, pn_out_valid,
        input  wr_ready, mode, operator, in, in_valid, busy, err, err_code
    );

    modport slave (
        input  wr_valid, wr_mode, wr_operator, wr_data, wr_last, pn_out_valid,
        output wr_ready, mode, operator, in, in_valid, busy, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/pn_token_feeder_store.sv
`default_nettype none
// ============================================================================
// Module   : pn_token_store
// Purpose  : DEPTH x (1+TOKW) token register file, one write, one async read.
// Revision : 1.0  initial release
// ============================================================================
module pn_token_store #(
    parameter int DEPTH = 12,
    parameter int TOKW  = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [TOKW:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [TOKW:0] rdata
);
    logic [TOKW:0] r_mem [DEPTH];

    // Contents need no reset: the feeder's write pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/pn_token_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pn_token_feeder
// Purpose  : Buffers, validates and replays one PN expression to the evaluator.
// Revision : 1.0  initial release
// ============================================================================
module pn_token_feeder
    import pn_pkg::*;
#(
    parameter int DEPTH = PN_MAX_TOK,
    parameter int TOKW  = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pn_token_feeder_if.slave  bus
);
    localparam int c_ptr_w  = $clog2(DEPTH + 1);
    localparam int c_addr_w = $clog2(DEPTH);

    pn_state_e            r_state, w_state_nxt;
    logic                 r_wr_ready, w_wr_ready_nxt;
    logic [1:0]           r_mode, w_mode_nxt;
    logic                 r_operator, w_operator_nxt;
    logic [TOKW-1:0]      r_in, w_in_nxt;
    logic                 r_in_valid, w_in_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_err, w_err_nxt;
    pn_err_e              r_err_code, w_err_code_nxt;
    logic [c_ptr_w-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [c_ptr_w-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic                 r_sbad, w_sbad_nxt;
    logic [3:0]           r_lvl, w_lvl_nxt;
    logic [1:0]           r_phase, w_phase_nxt;
    logic                 r_seen, w_seen_nxt;

    logic                 w_accept;
    logic                 w_first;
    logic [1:0]           w_tok_mode;
    logic [1:0]           w_chk_phase, w_chk_phase_nxt;
    logic [3:0]           w_chk_lvl, w_chk_lvl_nxt;
    logic                 w_chk_bad;
    logic                 w_end_ok;
    pn_err_e              w_fail;

    logic                 w_we;
    logic [c_addr_w-1:0]  w_waddr, w_raddr;
    logic [TOKW:0]        w_rdata;

    pn_token_store #(
        .DEPTH (DEPTH),
        .TOKW  (TOKW),
        .AW    (c_addr_w)
    ) u_store (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata ({bus.wr_operator, bus.wr_data}),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    assign w_accept = bus.wr_valid & r_wr_ready;

    // Incremental structure check of the token currently offered. The first
    // token of an expression uses the live wr_mode and fresh counters.
    always_comb begin
        w_first         = (r_state == ST_IDLE);
        w_tok_mode      = w_first ? bus.wr_mode : r_mode;
        w_chk_phase     = w_first ? 2'd0 : r_phase;
        w_chk_lvl       = w_first ? ((bus.wr_mode == PN_MODE_NPN) ? 4'd1 : 4'd0) : r_lvl;
        w_chk_phase_nxt = (w_chk_phase == 2'd2) ? 2'd0 : w_chk_phase + 2'd1;
        w_chk_lvl_nxt   = w_chk_lvl;
        w_chk_bad       = 1'b0;
        case (w_tok_mode)
            PN_MODE_GRP_PRE:  w_chk_bad = bus.wr_operator != (w_chk_phase == 2'd0);
            PN_MODE_GRP_POST: w_chk_bad = bus.wr_operator != (w_chk_phase == 2'd2);
            PN_MODE_NPN: begin
                if (w_chk_lvl == 4'd0)
                    w_chk_bad = 1'b1;
                else if (bus.wr_operator)
                    w_chk_lvl_nxt = w_chk_lvl + 4'd1;
                else
                    w_chk_lvl_nxt = w_chk_lvl - 4'd1;
            end
            default: begin
                if (bus.wr_operator) begin
                    if (w_chk_lvl < 4'd2)
                        w_chk_bad = 1'b1;
                    else
                        w_chk_lvl_nxt = w_chk_lvl - 4'd1;
                end else begin
                    w_chk_lvl_nxt = w_chk_lvl + 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        w_end_ok = 1'b1;
        if (r_mode == PN_MODE_NPN)
            w_end_ok = (r_lvl == 4'd0);
        else if (r_mode == PN_MODE_RPN)
            w_end_ok = (r_lvl == 4'd1);

        if (r_ovf)
            w_fail = PN_ERR_OVF;
        else if (!pn_count_ok(r_mode, int'(r_wr_ptr)))
            w_fail = PN_ERR_COUNT;
        else if (r_sbad || !w_end_ok)
            w_fail = PN_ERR_STRUCT;
        else
            w_fail = PN_ERR_NONE;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_operator_nxt = 1'b0;
        w_in_nxt       = '0;
        w_in_valid_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_ovf_nxt      = r_ovf;
        w_sbad_nxt     = r_sbad;
        w_lvl_nxt      = r_lvl;
        w_phase_nxt    = r_phase;
        w_seen_nxt     = r_seen;
        w_we           = 1'b0;
        w_waddr        = '0;
        w_raddr        = r_rd_ptr[c_addr_w-1:0];

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_we         = 1'b1;
                    w_mode_nxt   = bus.wr_mode;
                    w_wr_ptr_nxt = c_ptr_w'(1);
                    w_ovf_nxt    = 1'b0;
                    w_sbad_nxt   = w_chk_bad;
                    w_lvl_nxt    = w_chk_lvl_nxt;
                    w_phase_nxt  = w_chk_phase_nxt;
                    w_state_nxt  = bus.wr_last ? ST_CHECK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (r_wr_ptr == c_ptr_w'(DEPTH)) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_we         = 1'b1;
                        w_waddr      = r_wr_ptr[c_addr_w-1:0];
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        w_sbad_nxt   = r_sbad | w_chk_bad;
                        w_lvl_nxt    = w_chk_lvl_nxt;
                        w_phase_nxt  = w_chk_phase_nxt;
                    end
                    if (bus.wr_last)
                        w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_fail != PN_ERR_NONE) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_fail;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    // Entry 0 is prefetched here so in_valid rises on SEND entry.
                    w_raddr        = '0;
                    w_in_valid_nxt = 1'b1;
                    w_operator_nxt = w_rdata[TOKW];
                    w_in_nxt       = w_rdata[TOKW-1:0];
                    w_rd_ptr_nxt   = c_ptr_w'(1);
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_rd_ptr == r_wr_ptr) begin
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_in_valid_nxt = 1'b1;
                    w_operator_nxt = w_rdata[TOKW];
                    w_in_nxt       = w_rdata[TOKW-1:0];
                    w_rd_ptr_nxt   = r_rd_ptr + 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_seen && !bus.pn_out_valid) begin
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.pn_out_valid) begin
                    w_seen_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_wr_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b0;
            r_mode     <= 2'd0;
            r_operator <= 1'b0;
            r_in       <= '0;
            r_in_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= PN_ERR_NONE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_sbad     <= 1'b0;
            r_lvl      <= '0;
            r_phase    <= '0;
            r_seen     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ready <= w_wr_ready_nxt;
            r_mode     <= w_mode_nxt;
            r_operator <= w_operator_nxt;
            r_in       <= w_in_nxt;
            r_in_valid <= w_in_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_ovf      <= w_ovf_nxt;
            r_sbad     <= w_sbad_nxt;
            r_lvl      <= w_lvl_nxt;
            r_phase    <= w_phase_nxt;
            r_seen     <= w_seen_nxt;
        end
    end

    assign bus.wr_ready = r_wr_ready;
    assign bus.mode     = r_mode;
    assign bus.operator = r_operator;
    assign bus.in       = r_in;
    assign bus.in_valid = r_in_valid;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_pn_token_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pn_token_feeder
// Purpose  : Self-checking bench: expression table plus scoreboard of replay.
// Revision : 1.0  initial release
// ============================================================================
module tb_pn_token_feeder;
    import pn_pkg::*;

    typedef struct {
        logic [1:0]       mode;
        logic [1:0]       code;
        int               n;
        logic [15:0]      op;
        logic [15:0][2:0] dat;
    } vec_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       op;
        logic [2:0] d;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pn_token_feeder_if #(.TOKW(3)) bus();

    pn_token_feeder #(.DEPTH(12), .TOKW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    errors    = 0;
    int    checks    = 0;
    int    last_code = 0;
    bit    mon_en    = 1'b0;
    vec_t  vt[$];
    vec_t  cur;
    item_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nv(input logic [1:0] m, input logic [1:0] c);
        cur.mode = m;
        cur.code = c;
        cur.n    = 0;
        cur.op   = '0;
        cur.dat  = '0;
    endtask

    task automatic tk(input logic o, input logic [2:0] d);
        cur.op[cur.n]  = o;
        cur.dat[cur.n] = d;
        cur.n++;
    endtask

    task automatic ev();
        vt.push_back(cur);
    endtask

    // Replayed tokens: compared in order; outside bursts operator/in must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.in_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_in_valid: actual=1 required=0 at %0t", $time);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("replay_token", 32'({bus.mode, bus.operator, bus.in}), 32'(it));
                end
            end else begin
                chk("idle_outputs_zero", 32'({bus.operator, bus.in}), 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.wr_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wr_ready_wait", 32'(bus.wr_ready), 32'd1);
    endtask

    task automatic drive_tokens(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            bus.wr_valid    = 1'b1;
            bus.wr_mode     = (i == 0) ? v.mode : ~v.mode;
            bus.wr_operator = v.op[i];
            bus.wr_data     = v.dat[i];
            bus.wr_last     = (i == v.n - 1);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic push_expected(input vec_t v);
        item_t it;
        for (int i = 0; i < v.n; i++) begin
            it.mode = v.mode;
            it.op   = v.op[i];
            it.d    = v.dat[i];
            sb.push_back(it);
        end
    endtask

    task automatic run_vec(input int idx, input int pulse, input bit stress);
        vec_t v;
        int   cnt;
        v = vt[idx];
        wait_ready();
        if (v.code == 2'd0)
            push_expected(v);
        drive_tokens(v);
        chk("check_cycle_in_valid", 32'(bus.in_valid), 32'd0);
        chk("check_cycle_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("check_cycle_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        if (v.code != 2'd0) begin
            chk("err_pulse", 32'(bus.err), 32'd1);
            chk("err_code", 32'(bus.err_code), 32'(v.code));
            chk("err_wr_ready", 32'(bus.wr_ready), 32'd1);
            chk("err_busy", 32'(bus.busy), 32'd0);
            last_code = int'(v.code);
            @(posedge clk); #1;
            chk("err_one_cycle", 32'(bus.err), 32'd0);
            chk("err_code_held", 32'(bus.err_code), 32'(v.code));
        end else begin
            chk("burst_start", 32'(bus.in_valid), 32'd1);
            chk("burst_mode", 32'(bus.mode), 32'(v.mode));
            cnt = 0;
            while (bus.in_valid === 1'b1 && cnt < 40) begin
                if (stress) begin
                    bus.wr_valid     = 1'b1;
                    bus.wr_operator  = 1'b1;
                    bus.wr_data      = 3'd7;
                    bus.wr_last      = 1'b1;
                    bus.pn_out_valid = (cnt < 2);
                end
                cnt++;
                @(posedge clk); #1;
            end
            bus.wr_valid     = 1'b0;
            bus.wr_last      = 1'b0;
            bus.pn_out_valid = 1'b0;
            chk("burst_len", 32'(cnt), 32'(v.n));
            chk("burst_all_popped", 32'(sb.size()), 32'd0);
            chk("wait_wr_ready", 32'(bus.wr_ready), 32'd0);
            repeat (3) begin @(posedge clk); #1; end
            chk("wait_hold_busy", 32'(bus.busy), 32'd1);
            for (int p = 0; p < pulse; p++) begin
                bus.pn_out_valid = 1'b1;
                @(posedge clk); #1;
                chk("wait_during_pulse", 32'(bus.wr_ready), 32'd0);
            end
            bus.pn_out_valid = 1'b0;
            @(posedge clk); #1;
            chk("wait_done_ready", 32'(bus.wr_ready), 32'd1);
            chk("wait_done_busy", 32'(bus.busy), 32'd0);
            chk("err_code_kept", 32'(bus.err_code), 32'(last_code));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // 0: grouped prefix, 6 tokens
        nv(PN_MODE_GRP_PRE, 2'd0);
        tk(1, 0); tk(0, 3); tk(0, 2); tk(1, 2); tk(0, 4); tk(0, 5); ev();
        // 1: RPN 3 4 + 2 *
        nv(PN_MODE_RPN, 2'd0);
        tk(0, 3); tk(0, 4); tk(1, 0); tk(0, 2); tk(1, 2); ev();
        // 2: NPN + 3 4 5 + -> need exhausted early
        nv(PN_MODE_NPN, 2'd2);
        tk(1, 0); tk(0, 3); tk(0, 4); tk(0, 5); tk(1, 0); ev();
        // 3: 13 operands, grouped postfix -> overflow
        nv(PN_MODE_GRP_POST, 2'd3);
        for (int i = 0; i < 13; i++) tk(0, 3'(i)); ev();
        // 4: grouped postfix, 6 tokens
        nv(PN_MODE_GRP_POST, 2'd0);
        tk(0, 1); tk(0, 2); tk(1, 1); tk(0, 6); tk(0, 7); tk(1, 3); ev();
        // 5: grouped prefix, 7 tokens -> count
        nv(PN_MODE_GRP_PRE, 2'd1);
        tk(1, 0); tk(0, 1); tk(0, 2); tk(1, 1); tk(0, 3); tk(0, 4); tk(1, 2); ev();
        // 6: NPN * + 1 2 3
        nv(PN_MODE_NPN, 2'd0);
        tk(1, 2); tk(1, 0); tk(0, 1); tk(0, 2); tk(0, 3); ev();
        // 7: RPN + 1 2 3 4 -> operator with empty stack
        nv(PN_MODE_RPN, 2'd2);
        tk(1, 0); tk(0, 1); tk(0, 2); tk(0, 3); tk(0, 4); ev();
        // 8: grouped prefix, 12 tokens (full store)
        nv(PN_MODE_GRP_PRE, 2'd0);
        for (int i = 0; i < 4; i++) begin tk(1, 3'(i)); tk(0, 3'(i + 1)); tk(0, 3'(7 - i)); end
        ev();
        // 9: NPN, 6 tokens -> count
        nv(PN_MODE_NPN, 2'd1);
        tk(1, 0); tk(0, 1); tk(0, 2); tk(0, 3); tk(0, 4); tk(0, 5); ev();
        // 10: RPN, 12 operands -> count, no overflow
        nv(PN_MODE_RPN, 2'd1);
        for (int i = 0; i < 12; i++) tk(0, 3'(i)); ev();
        // 11: grouped prefix, operand first -> structure
        nv(PN_MODE_GRP_PRE, 2'd2);
        tk(0, 1); tk(1, 0); tk(0, 2); tk(1, 1); tk(0, 3); tk(0, 4); ev();
        // 12: single token -> count
        nv(PN_MODE_GRP_PRE, 2'd1);
        tk(1, 0); ev();
        // 13: RPN 1 2 + 3 * 4 - 5 +
        nv(PN_MODE_RPN, 2'd0);
        tk(0, 1); tk(0, 2); tk(1, 0); tk(0, 3); tk(1, 2); tk(0, 4); tk(1, 1); tk(0, 5); tk(1, 0); ev();
        // 14: NPN - + 1 2 * 3 4
        nv(PN_MODE_NPN, 2'd0);
        tk(1, 1); tk(1, 0); tk(0, 1); tk(0, 2); tk(1, 2); tk(0, 3); tk(0, 4); ev();

        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_mode = 2'd0; bus.wr_operator = 1'b0;
        bus.wr_data = 3'd0; bus.wr_last = 1'b0; bus.pn_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        chk("rst_mode", 32'(bus.mode), 32'd0);
        chk("rst_tok", 32'({bus.operator, bus.in}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            run_vec(i, 1 + (i % 3), (i == 6));

        // Reset landing on the third SEND cycle of an RPN burst
        wait_ready();
        push_expected(vt[1]);
        drive_tokens(vt[1]);
        @(posedge clk); #1;
        chk("rstburst_start", 32'(bus.in_valid), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstburst_in_valid", 32'(bus.in_valid), 32'd0);
        chk("rstburst_busy", 32'(bus.busy), 32'd0);
        chk("rstburst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rstburst_popped", 32'(sb.size()), 32'd2);
        sb.delete();
        rst = 1'b0;
        last_code = 0;
        @(posedge clk); #1;
        chk("rstburst_release_ready", 32'(bus.wr_ready), 32'd1);
        chk("rstburst_release_busy", 32'(bus.busy), 32'd0);
        chk("rstburst_err_code", 32'(bus.err_code), 32'd0);
        chk("rstburst_mode", 32'(bus.mode), 32'd0);
        run_vec(13, 2, 1'b0);
        run_vec(0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
